// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// response error codes, FSM state encoding and the alignment check.
// Latency: n/a (package). Backpressure: n/a.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

  // Size 2'b11 is illegal and is reported the same way as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = |addr_lo;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and replicated store data from size/addr,
// plus lane extraction and zero/sign extension of load data.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: size, addr_lo, ld_unsigned, st_data, ld_raw -> be, st_lane, ld_ext.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] st_lane,
  output logic [31:0] ld_ext
);

  logic [31:0] shifted;

  always_comb begin
    be      = 4'b0000;
    st_lane = st_data;
    ld_ext  = '0;
    // Bring the addressed lane down to bits [7:0] / [15:0].
    shifted = ld_raw >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << addr_lo;
        st_lane = {4{st_data[7:0]}};
        ld_ext  = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be      = 4'b0011 << addr_lo;
        st_lane = {2{st_data[15:0]}};
        ld_ext  = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be      = 4'b1111;
        st_lane = st_data;
        ld_ext  = shifted;
      end
      default: begin
        be      = 4'b0000;
        st_lane = st_data;
        ld_ext  = '0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, lane-steered strobes to
// memory, aligned/extended load data back for writeback.
// Latency: 2 cycles request-to-rsp_valid minimum (1 for alignment errors);
// req_ready is low from acceptance until the response pulse, one access in flight.
// Ports: req_* from execute, mem_* to data memory (mem_ack ends an access),
//        rsp_* one-cycle response to writeback.
// Optional: define LSU_TIMEOUT_EN to abort accesses after TIMEOUT cycles with rsp_err=10.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [4:0]    req_rd,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [4:0]    rsp_rd,
  output logic          rsp_we,
  output logic [1:0]    rsp_err
);

  lsu_state_t    state_q, state_d;
  logic          store_q, store_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [4:0]    rd_q, rd_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] data_q, data_d;

  logic [3:0]    be;
  logic [DW-1:0] st_lane;
  logic [DW-1:0] ld_ext;
  logic          in_access;
  logic          in_resp;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Lane logic works from the latched request so outputs stay stable in ACCESS.
  lsu_lane_align u_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .ld_unsigned (uns_q),
    .st_data     (wdata_q),
    .ld_raw      (mem_rdata),
    .be          (be),
    .st_lane     (st_lane),
    .ld_ext      (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    data_d  = data_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          data_d  = '0;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            err_d   = ERR_ALIGN;
            state_d = ST_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_ACCESS;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_ACCESS: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (mem_ack) begin
          data_d  = store_q ? '0 : ld_ext;
          state_d = ST_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          data_d  = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= ERR_OK;
      data_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      data_q  <= data_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs decode straight from state, so an async reset drops strobes at once.
  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  assign req_ready = (state_q == ST_IDLE);
  assign mem_read  = in_access & ~store_q;
  assign mem_write = in_access & store_q;
  assign mem_addr  = in_access ? {addr_q[AW-1:2], 2'b00} : '0;
  assign mem_be    = in_access ? be : 4'b0000;
  assign mem_wdata = in_access ? st_lane : '0;

  assign rsp_valid = in_resp;
  assign rsp_data  = in_resp ? data_q : '0;
  assign rsp_rd    = in_resp ? rd_q : '0;
  assign rsp_we    = in_resp & ~store_q & (err_q == ERR_OK);
  assign rsp_err   = in_resp ? err_q : ERR_OK;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses plus
// hand-written sequences for ack-in-IDLE, reset mid-access and timeout.
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_we;
  logic [1:0]  rsp_err;

  load_store_unit #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_we(rsp_we), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_vec = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, cur_vec, act, exp);
    end
  endtask

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [1:0]  err;
    logic [31:0] data;
    logic        we;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic un,
                              input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] rdat, input int dly, input logic [3:0] be,
                              input logic [31:0] ma, input logic [31:0] mw, input logic [1:0] er,
                              input logic [31:0] dat, input logic we);
    vec_t v;
    v.store = st; v.size = sz; v.uns = un; v.addr = ad; v.wdata = wd; v.rd = rd;
    v.rdata = rdat; v.delay = dly; v.be = be; v.maddr = ma; v.mwdata = mw;
    v.err = er; v.data = dat; v.we = we;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = v.store; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h1111_1111;
    if (v.err == ERR_ALIGN) begin
      chk("align_no_strobe", {30'b0, mem_read, mem_write}, 32'd0);
    end else begin
      for (int k = 0; k <= v.delay; k++) begin
        chk("mem_read", {31'b0, mem_read}, {31'b0, ~v.store});
        chk("mem_write", {31'b0, mem_write}, {31'b0, v.store});
        chk("mem_addr", mem_addr, v.maddr);
        chk("mem_be", {28'b0, mem_be}, {28'b0, v.be});
        chk("ready_busy", {31'b0, req_ready}, 32'd0);
        chk("no_early_rsp", {31'b0, rsp_valid}, 32'd0);
        if (v.store) chk("mem_wdata", mem_wdata, v.mwdata);
        if (k == v.delay) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
      end
    end
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_err", {30'b0, rsp_err}, {30'b0, v.err});
    chk("rsp_we", {31'b0, rsp_we}, {31'b0, v.we});
    chk("rsp_data", rsp_data, v.data);
    chk("strobes_off", {30'b0, mem_read, mem_write}, 32'd0);
    if (v.we) chk("rsp_rd", {27'b0, rsp_rd}, {27'b0, v.rd});
    @(negedge clk);
    chk("rsp_pulse_end", {31'b0, rsp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int pulses;
    int cnt;
    //            st    sz       un    addr           wdata          rd     rdata          dly be       maddr          mwdata         err        data           we
    vecs[0]  = mk(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0,         5'd1,  32'hDEAD_BEEF, 0, 4'b1111, 32'h0000_0010, 32'h0,         ERR_OK,    32'hDEAD_BEEF, 1'b1);
    vecs[1]  = mk(1'b0, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h0,         5'd2,  32'h8000_0000, 0, 4'b1000, 32'h0000_0010, 32'h0,         ERR_OK,    32'hFFFF_FF80, 1'b1);
    vecs[2]  = mk(1'b0, SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0,         5'd3,  32'h8000_0000, 0, 4'b1000, 32'h0000_0010, 32'h0,         ERR_OK,    32'h0000_0080, 1'b1);
    vecs[3]  = mk(1'b1, SZ_HALF, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 5'd4,  32'h0,         3, 4'b1100, 32'h0000_0020, 32'hABCD_ABCD, ERR_OK,    32'h0,         1'b0);
    vecs[4]  = mk(1'b0, SZ_WORD, 1'b0, 32'h0000_0005, 32'h0,         5'd5,  32'h0,         0, 4'b0000, 32'h0,         32'h0,         ERR_ALIGN, 32'h0,         1'b0);
    vecs[5]  = mk(1'b0, SZ_HALF, 1'b0, 32'h0000_0102, 32'h0,         5'd6,  32'h8001_1234, 1, 4'b1100, 32'h0000_0100, 32'h0,         ERR_OK,    32'hFFFF_8001, 1'b1);
    vecs[6]  = mk(1'b1, SZ_BYTE, 1'b0, 32'h0000_0041, 32'h1234_5677, 5'd7,  32'h0,         1, 4'b0010, 32'h0000_0040, 32'h7777_7777, ERR_OK,    32'h0,         1'b0);
    vecs[7]  = mk(1'b1, SZ_WORD, 1'b0, 32'h0000_0044, 32'hCAFE_F00D, 5'd8,  32'h0,         0, 4'b1111, 32'h0000_0044, 32'hCAFE_F00D, ERR_OK,    32'h0,         1'b0);
    vecs[8]  = mk(1'b0, 2'b11,   1'b0, 32'h0000_0000, 32'h0,         5'd9,  32'h0,         0, 4'b0000, 32'h0,         32'h0,         ERR_ALIGN, 32'h0,         1'b0);
    vecs[9]  = mk(1'b0, SZ_HALF, 1'b0, 32'h0000_0033, 32'h0,         5'd10, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         ERR_ALIGN, 32'h0,         1'b0);
    vecs[10] = mk(1'b0, SZ_BYTE, 1'b1, 32'h0000_0000, 32'h0,         5'd11, 32'h0000_00FF, 2, 4'b0001, 32'h0,         32'h0,         ERR_OK,    32'h0000_00FF, 1'b1);
    vecs[11] = mk(1'b0, SZ_BYTE, 1'b0, 32'h0000_0201, 32'h0,         5'd12, 32'h0000_7F00, 0, 4'b0010, 32'h0000_0200, 32'h0,         ERR_OK,    32'h0000_007F, 1'b1);
    vecs[12] = mk(1'b0, SZ_HALF, 1'b1, 32'h0000_0300, 32'h0,         5'd13, 32'hFFFF_8000, 0, 4'b0011, 32'h0000_0300, 32'h0,         ERR_OK,    32'h0000_8000, 1'b1);
    vecs[13] = mk(1'b1, SZ_WORD, 1'b0, 32'h0000_0002, 32'h0BAD_0BAD, 5'd14, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         ERR_ALIGN, 32'h0,         1'b0);

    // Reset values while rst_n is low.
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_rsp", {25'b0, rsp_valid, rsp_we, rsp_err, rsp_rd[2:0]}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // An ack while idle must not create a response.
    cur_vec = 100;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("idle_ack_no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("idle_ack_ready", {31'b0, req_ready}, 32'd1);
    mem_ack = 1'b0;

    // Reset in the middle of an access: strobes drop without a clock edge, no response.
    cur_vec = 101;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 32'h0000_0008; req_rd = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_read", {31'b0, mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_read", {31'b0, mem_read}, 32'd0);
    chk("async_rst_addr", mem_addr, 32'd0);
    chk("async_rst_be", {28'b0, mem_be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("rst_no_rsp", pulses, 32'd0);
    chk("rst_ready_after", {31'b0, req_ready}, 32'd1);

`ifdef LSU_TIMEOUT_EN
    // Memory never acks: strobe stays up TIMEOUT cycles, then a timeout response.
    cur_vec = 102;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = SZ_WORD; req_addr = 32'h0000_0020;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && mem_read; k++) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo_read_cycles", cnt, TMO);
    chk("tmo_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("tmo_rsp_err", {30'b0, rsp_err}, {30'b0, ERR_TIMEOUT});
    chk("tmo_rsp_we", {31'b0, rsp_we}, 32'd0);
    @(negedge clk);
    chk("tmo_idle", {31'b0, req_ready}, 32'd1);
`else
    cnt = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
